// File: rtl/router_vcreq_pkg.sv
// Shared definitions for the input-VC requester: flit type codes, port indices and XY routing.
package router_vcreq_pkg;

  localparam int NO_OF_PORTS = 5;
  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_S = 3;
  localparam int PORT_W = 4;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACTIVE,
    S_RELEASE
  } vcreq_state_t;

  // Dimension-ordered routing: resolve X first, then Y, then eject locally.
  function automatic logic [NO_OF_PORTS-1:0] xy_route(input logic [3:0] dx, input logic [3:0] dy,
                                                      input logic [3:0] my_x, input logic [3:0] my_y);
    logic [NO_OF_PORTS-1:0] p;
    p = '0;
    if (dx > my_x)      p[PORT_E] = 1'b1;
    else if (dx < my_x) p[PORT_W] = 1'b1;
    else if (dy > my_y) p[PORT_N] = 1'b1;
    else if (dy < my_y) p[PORT_S] = 1'b1;
    else                p[PORT_L] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/router_vcreq_fifo.sv
// Synchronous flit FIFO with count-based full/empty; push and pop together when full keeps the count.
module router_vcreq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_vcreq.sv
// Input-VC requester: buffers flits, XY-routes the head, holds the won output VC until the tail leaves.
module router_vcreq
  import router_vcreq_pkg::*;
#(
  parameter int         FLIT_W = 32,
  parameter int         DEPTH  = 4,
  parameter logic [3:0] MY_X   = 4'd0,
  parameter logic [3:0] MY_Y   = 4'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_W-1:0]      in_flit,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NO_OF_PORTS-1:0] vc0_req,
  output logic [NO_OF_PORTS-1:0] vc1_req,
  input  logic [NO_OF_PORTS-1:0] vc0_grant,
  input  logic [NO_OF_PORTS-1:0] vc1_grant,
  output logic [FLIT_W-1:0]      out_flit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NO_OF_PORTS-1:0] out_port,
  output logic                   out_vc,
  output logic                   err
);

  vcreq_state_t           state;
  logic [NO_OF_PORTS-1:0] route;
  logic [NO_OF_PORTS-1:0] next_route;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   granted;
  logic                   is_head;
  logic                   is_tail;
  flit_type_t             ftype;

  router_vcreq_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_flit),
    .pop   (pop),
    .rdata (out_flit),
    .full  (full),
    .empty (empty)
  );

  assign ftype      = flit_type_t'(out_flit[FLIT_W-1 -: 2]);
  assign is_head    = (ftype == FT_HEAD) || (ftype == FT_SINGLE);
  assign is_tail    = (ftype == FT_TAIL) || (ftype == FT_SINGLE);
  assign next_route = xy_route(out_flit[7:4], out_flit[3:0], MY_X, MY_Y);

  assign in_ready = ~full & ~rst;
  assign push     = in_valid & in_ready;

  // The arbiter grant is combinational, so forwarding is gated by its live value.
  assign granted   = out_vc ? |(vc1_grant & out_port) : |(vc0_grant & out_port);
  assign out_valid = (state == S_ACTIVE) & ~empty & granted;
  assign drop      = (state == S_IDLE) & ~empty & ~is_head;
  assign pop       = (out_valid & out_ready) | drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      route    <= '0;
      vc0_req  <= '0;
      vc1_req  <= '0;
      out_port <= '0;
      out_vc   <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            if (is_head) begin
              route   <= next_route;
              vc0_req <= next_route;
              vc1_req <= next_route;
              state   <= S_REQ;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (|(vc0_grant & route)) begin
            out_vc   <= 1'b0;
            out_port <= route;
            vc1_req  <= '0;
            state    <= S_ACTIVE;
          end else if (|(vc1_grant & route)) begin
            out_vc   <= 1'b1;
            out_port <= route;
            vc0_req  <= '0;
            state    <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (out_valid && out_ready && is_tail) begin
            vc0_req <= '0;
            vc1_req <= '0;
            state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          out_port <= '0;
          out_vc   <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_vcreq.sv
// Directed bench for router_vcreq at MY=(1,1); the arbiter is modelled as grant-follows-request per VC.
module tb_router_vcreq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  vc0_req, vc1_req, vc0_grant, vc1_grant;
  logic [31:0] out_flit;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_port;
  logic        out_vc;
  logic        err;
  logic        g0_follow, g1_follow;

  int nvec = 0;
  int nmis = 0;
  logic [31:0] pkt [8];

  always #5 clk = ~clk;

  assign vc0_grant = g0_follow ? vc0_req : 5'b0;
  assign vc1_grant = g1_follow ? vc1_req : 5'b0;

  router_vcreq #(.FLIT_W(32), .DEPTH(4), .MY_X(4'd1), .MY_Y(4'd1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vc0_req   (vc0_req),
    .vc1_req   (vc1_req),
    .vc0_grant (vc0_grant),
    .vc1_grant (vc1_grant),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_port  (out_port),
    .out_vc    (out_vc),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [1:0] ty, input int id, input logic [3:0] dx,
                                     input logic [3:0] dy);
    logic [21:0] tag;
    tag = 22'(id);
    return {ty, tag, dx, dy};
  endfunction

  // Streams pkt[0:n-1] in and checks it comes out in order on port exp_port, then checks RELEASE/IDLE.
  // mode 0: out_ready toggles each cycle; mode 1: out_ready held low for 10 cycles first.
  task automatic run_packet(input string tag, input int n, input int mode, input logic [4:0] exp_port);
    int pi = 0;
    int oi = 0;
    bit done = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      in_valid  = (pi < n);
      in_flit   = (pi < n) ? pkt[pi] : 32'h0;
      out_ready = (mode == 0) ? c[0] : (c >= 10);
      #1;
      if (mode == 1 && c == 9) begin
        chk({tag, "_accepted_before_full"}, 32'(pi), 32'd4);
        chk({tag, "_in_ready_full"}, {31'b0, in_ready}, 32'd0);
      end
      if (in_valid && in_ready) pi++;
      if (out_valid && out_ready) begin
        chk({tag, "_flit"}, out_flit, pkt[oi]);
        chk({tag, "_port"}, {27'b0, out_port}, {27'b0, exp_port});
        oi++;
        if (oi == n) done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_count"}, 32'(oi), 32'(n));
    chk({tag, "_release_reqs"}, {22'b0, vc0_req, vc1_req}, 32'd0);
    chk({tag, "_release_port"}, {27'b0, out_port}, {27'b0, exp_port});
    chk({tag, "_release_valid"}, {31'b0, out_valid}, 32'd0);
    tick();
    chk({tag, "_idle_port"}, {27'b0, out_port}, 32'd0);
    chk({tag, "_idle_reqs"}, {22'b0, vc0_req, vc1_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_flit = '0; in_valid = 1'b0; out_ready = 1'b0;
    g0_follow = 1'b1; g1_follow = 1'b0;
    tick(); tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_reqs", {22'b0, vc0_req, vc1_req}, 32'd0);
    chk("rst_outs", {25'b0, out_valid, out_port, out_vc, err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 1: single flit east via VC0
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_flit = mk(2'b11, 1, 4'd3, 4'd1);
    tick();
    in_valid = 1'b0;
    chk("t1_n1_req", {27'b0, vc0_req}, 32'd0);
    tick();
    chk("t1_n2_vc0_req", {27'b0, vc0_req}, 32'h04);
    chk("t1_n2_vc1_req", {27'b0, vc1_req}, 32'h04);
    chk("t1_n2_valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("t1_n3_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_n3_port", {27'b0, out_port}, 32'h04);
    chk("t1_n3_vc", {31'b0, out_vc}, 32'd0);
    chk("t1_n3_vc1_drop", {27'b0, vc1_req}, 32'd0);
    chk("t1_n3_flit", out_flit, mk(2'b11, 1, 4'd3, 4'd1));
    tick();
    chk("t1_release_reqs", {22'b0, vc0_req, vc1_req}, 32'd0);
    chk("t1_release_port", {27'b0, out_port}, 32'h04);
    tick();
    chk("t1_idle_port", {27'b0, out_port}, 32'd0);

    // 2: same packet won on VC1
    g0_follow = 1'b0; g1_follow = 1'b1;
    tick();
    in_valid = 1'b1; in_flit = mk(2'b11, 2, 4'd3, 4'd1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t2_n2_vc0_req", {27'b0, vc0_req}, 32'h04);
    chk("t2_n2_vc1_req", {27'b0, vc1_req}, 32'h04);
    tick();
    chk("t2_n3_vc", {31'b0, out_vc}, 32'd1);
    chk("t2_n3_vc0_drop", {27'b0, vc0_req}, 32'd0);
    chk("t2_n3_vc1_hold", {27'b0, vc1_req}, 32'h04);
    chk("t2_n3_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("t2_release_reqs", {22'b0, vc0_req, vc1_req}, 32'd0);
    tick(); tick();

    // 3: local packet with out_ready toggling
    g0_follow = 1'b1; g1_follow = 1'b0;
    pkt[0] = mk(2'b01, 10, 4'd1, 4'd1);
    pkt[1] = mk(2'b00, 11, 4'd7, 4'd7);
    pkt[2] = mk(2'b00, 12, 4'd2, 4'd5);
    pkt[3] = mk(2'b10, 13, 4'd0, 4'd9);
    run_packet("t3", 4, 0, 5'b00001);
    tick();

    // 4: six flits east with the crossbar initially stalled
    pkt[0] = mk(2'b01, 20, 4'd3, 4'd1);
    for (int i = 1; i < 5; i++) pkt[i] = mk(2'b00, 20 + i, 4'(i), 4'(i));
    pkt[5] = mk(2'b10, 25, 4'd0, 4'd0);
    run_packet("t4", 6, 1, 5'b00100);
    tick();

    // 5: stray body flit while IDLE
    in_valid = 1'b1; in_flit = mk(2'b00, 30, 4'd3, 4'd1);
    tick();
    in_valid = 1'b0;
    chk("t5_n1_err", {31'b0, err}, 32'd0);
    tick();
    chk("t5_n2_err", {31'b0, err}, 32'd1);
    chk("t5_n2_reqs", {22'b0, vc0_req, vc1_req}, 32'd0);
    tick();
    chk("t5_n3_err", {31'b0, err}, 32'd0);
    chk("t5_n3_reqs", {22'b0, vc0_req, vc1_req}, 32'd0);
    pkt[0] = mk(2'b11, 31, 4'd0, 4'd1);
    run_packet("t5_after", 1, 0, 5'b10000);
    tick();

    // 6: reset while ACTIVE mid-packet
    out_ready = 1'b0;
    in_valid = 1'b1; in_flit = mk(2'b01, 40, 4'd3, 4'd1);
    tick();
    in_flit = mk(2'b00, 41, 4'd3, 4'd1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6_active_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_reqs", {22'b0, vc0_req, vc1_req}, 32'd0);
    chk("t6_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_port", {27'b0, out_port}, 32'd0);
    chk("t6_in_ready", {31'b0, in_ready}, 32'd1);
    tick(); tick(); tick();
    chk("t6_empty_no_req", {22'b0, vc0_req, vc1_req}, 32'd0);
    chk("t6_empty_no_err", {31'b0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
